// File: rtl/widen_arbiter.sv
// rtl/widen_arbiter.sv - round-robin A(16b)/B(32b) arbiter widening into a 64-bit output register with running sum
// Build option: WIDEN_ARBITER_SIGN_EXT_EN sign-extends the B operand (zero-extends otherwise).
module widen_arbiter #(
  parameter logic PRIO_B_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [15:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        acc_clear,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_src,
  output logic [63:0] out_sum
);

  typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

  state_t      r_state;
  logic [63:0] r_out_data;
  logic        r_out_src;
  logic [63:0] r_sum;
  logic        r_prio_b;

  logic        w_can_accept;
  logic        w_grant_a;
  logic        w_grant_b;
  logic        w_xfer_a;
  logic        w_xfer_b;
  logic        w_xfer;
  logic [63:0] w_a_wide;
  logic [63:0] w_b_wide;
  logic [63:0] w_wide;
  logic [63:0] w_sum_base;

  assign w_a_wide = {48'b0, a_data};
`ifdef WIDEN_ARBITER_SIGN_EXT_EN
  assign w_b_wide = {{32{b_data[31]}}, b_data};
`else
  assign w_b_wide = {32'b0, b_data};
`endif

  // r_prio_b names the side that wins a two-way contest; it flips only on a real transfer.
  assign w_grant_a    = a_valid & (~b_valid | ~r_prio_b);
  assign w_grant_b    = b_valid & (~a_valid | r_prio_b);
  assign w_can_accept = (r_state == S_EMPTY) | out_ready;

  assign a_ready  = ~rst & w_can_accept & w_grant_a;
  assign b_ready  = ~rst & w_can_accept & w_grant_b;
  assign w_xfer_a = a_valid & a_ready;
  assign w_xfer_b = b_valid & b_ready;
  assign w_xfer   = w_xfer_a | w_xfer_b;

  assign w_wide     = w_xfer_b ? w_b_wide : w_a_wide;
  assign w_sum_base = acc_clear ? 64'b0 : r_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_EMPTY;
      r_out_data <= 64'b0;
      r_out_src  <= 1'b0;
      r_sum      <= 64'b0;
      r_prio_b   <= PRIO_B_FIRST;
    end else begin
      case (r_state)
        S_EMPTY: if (w_xfer) r_state <= S_FULL;
        S_FULL:  if (out_ready && !w_xfer) r_state <= S_EMPTY;
        default: r_state <= S_EMPTY;
      endcase
      if (w_xfer) begin
        r_out_data <= w_wide;
        r_out_src  <= w_xfer_b;
        r_prio_b   <= w_xfer_a;
        r_sum      <= w_sum_base + w_wide;
      end else if (acc_clear) begin
        r_sum <= 64'b0;
      end
    end
  end

  assign out_valid = (r_state == S_FULL);
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_sum   = r_sum;

endmodule

// File: tb/tb_widen_arbiter.sv
// tb/tb_widen_arbiter.sv - directed scoreboard bench for widen_arbiter
module tb_widen_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic [15:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [31:0] b_data;
  logic        b_ready;
  logic        acc_clear;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_src;
  logic [63:0] out_sum;

  widen_arbiter #(.PRIO_B_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .acc_clear(acc_clear),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src), .out_sum(out_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        src;
    logic [63:0] data;
  } ent_t;

  ent_t        q[$];
  logic        m_prio_b;
  logic        m_full;
  logic [63:0] m_sum;
  int          n_cmp;
  int          n_bad;

  function automatic logic [63:0] wide_b(input logic [31:0] d);
`ifdef WIDEN_ARBITER_SIGN_EXT_EN
    return {{32{d[31]}}, d};
`else
    return {32'b0, d};
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle from a negedge, check readies/held output, clock, then check the result.
  task automatic step(input logic av, input logic [15:0] ad, input logic bv,
                      input logic [31:0] bd, input logic ordy, input logic clr);
    logic ca, ga, gb, ta, tb;
    logic [63:0] w;
    ent_t e;
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd;
    out_ready = ordy; acc_clear = clr;
    #1;
    ca = !m_full | ordy;
    ga = av & (!bv | !m_prio_b);
    gb = bv & (!av | m_prio_b);
    chk("a_ready", {63'b0, a_ready}, {63'b0, ca & ga});
    chk("b_ready", {63'b0, b_ready}, {63'b0, ca & gb});
    chk("out_valid_pre", {63'b0, out_valid}, {63'b0, m_full});
    if (m_full) begin
      chk("out_data_held", out_data, q[0].data);
      chk("out_src_held", {63'b0, out_src}, {63'b0, q[0].src});
      if (ordy) begin
        void'(q.pop_front());
        m_full = 1'b0;
      end
    end
    ta = ca & ga;
    tb = ca & gb;
    if (ta | tb) begin
      w = ta ? {48'b0, ad} : wide_b(bd);
      e.src = tb;
      e.data = w;
      q.push_back(e);
      m_full = 1'b1;
      m_prio_b = ta;
      m_sum = (clr ? 64'b0 : m_sum) + w;
    end else if (clr) begin
      m_sum = 64'b0;
    end
    @(posedge clk);
    #1;
    chk("out_sum", out_sum, m_sum);
    chk("out_valid_post", {63'b0, out_valid}, {63'b0, m_full});
    if (m_full) chk("out_data_new", out_data, q[q.size()-1].data);
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    m_prio_b = 1'b0; m_full = 1'b0; m_sum = 64'b0;
    rst = 1'b1;
    a_valid = 1'b1; a_data = 16'h1234; b_valid = 1'b1; b_data = 32'h5678;
    out_ready = 1'b1; acc_clear = 1'b0;
    @(posedge clk); #1;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_src", {63'b0, out_src}, 64'd0);
    chk("rst_out_sum", out_sum, 64'd0);
    chk("rst_a_ready", {63'b0, a_ready}, 64'd0);
    chk("rst_b_ready", {63'b0, b_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // single A
    step(1'b1, 16'hBEEF, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("beef_data", out_data, 64'h0000_0000_0000_BEEF);
    chk("beef_src", {63'b0, out_src}, 64'd0);
    chk("beef_sum", out_sum, 64'hBEEF);

    // B all-ones widening
    step(1'b0, 16'h0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
`ifdef WIDEN_ARBITER_SIGN_EXT_EN
    chk("b_ext", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
`else
    chk("b_ext", out_data, 64'h0000_0000_FFFF_FFFF);
`endif
    chk("b_src", {63'b0, out_src}, 64'd1);
    step(1'b0, 16'h0, 1'b0, 32'h0, 1'b1, 1'b0);

    // fairness: A,B,A,B with no bubble
    step(1'b1, 16'h1111, 1'b1, 32'h2222_2222, 1'b1, 1'b0);
    chk("fair0", {63'b0, out_src}, 64'd0);
    step(1'b1, 16'h3333, 1'b1, 32'h4444_4444, 1'b1, 1'b0);
    chk("fair1", {63'b0, out_src}, 64'd1);
    step(1'b1, 16'h5555, 1'b1, 32'h6666_6666, 1'b1, 1'b0);
    chk("fair2", {63'b0, out_src}, 64'd0);
    step(1'b1, 16'h7777, 1'b1, 32'h8888_8888, 1'b1, 1'b0);
    chk("fair3", {63'b0, out_src}, 64'd1);
    chk("fair3_data", out_data, wide_b(32'h8888_8888));

    // back-pressure: held for 3 cycles, then drain+refill picks A
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'h9999 + 16'(i), 1'b1, 32'hAAAA_0000 + 32'(i), 1'b0, 1'b0);
      chk("stall_data", out_data, wide_b(32'h8888_8888));
    end
    step(1'b1, 16'hABCD, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    chk("refill_src", {63'b0, out_src}, 64'd0);
    chk("refill_data", out_data, 64'hABCD);
    step(1'b0, 16'h0, 1'b0, 32'h0, 1'b1, 1'b0);

    // accumulator clear collision
    step(1'b0, 16'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("clr_alone0", out_sum, 64'd0);
    step(1'b1, 16'h0010, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("sum_10", out_sum, 64'h10);
    step(1'b1, 16'h0005, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("clr_collide", out_sum, 64'h5);
    step(1'b0, 16'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("clr_alone1", out_sum, 64'd0);

    // asynchronous reset while FULL
    step(1'b1, 16'h0007, 1'b0, 32'h0, 1'b0, 1'b0);
    a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {63'b0, out_valid}, 64'd0);
    chk("arst_data", out_data, 64'd0);
    chk("arst_sum", out_sum, 64'd0);
    chk("arst_a_ready", {63'b0, a_ready}, 64'd0);
    chk("arst_b_ready", {63'b0, b_ready}, 64'd0);
    @(posedge clk); #1;
    chk("arst_a_ready_hold", {63'b0, a_ready}, 64'd0);
    chk("arst_b_ready_hold", {63'b0, b_ready}, 64'd0);
    chk("arst_valid_hold", {63'b0, out_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_full = 1'b0; m_sum = 64'b0; m_prio_b = 1'b0;
    step(1'b1, 16'h0003, 1'b1, 32'h0000_0009, 1'b1, 1'b0);
    chk("post_rst_src", {63'b0, out_src}, 64'd0);
    chk("post_rst_sum", out_sum, 64'h3);
    step(1'b0, 16'h0, 1'b0, 32'h0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
